// File: rtl/strip_feature_pkg.sv
// Shared parameters and mode encoding for the strip feature blocks.
// Imported by the strip transition counter and its helpers.
package strip_feature_pkg;

    localparam int HEIGHT_DEF = 28;
    localparam int WIDTH_DEF  = 28;
    localparam int CNT_W_DEF  = 16;

    localparam int MODE_V = 0;
    localparam int MODE_H = 1;

    typedef logic [1:0] mode_t;

endpackage

// File: rtl/strip_popcount.sv
// Combinational population count of an N-bit vector.
// Count width is clog2(N+1) so an all-ones input still fits.
module strip_popcount #(
    parameter int N = 8
) (
    input  logic [N-1:0]             bits,
    output logic [$clog2(N+1)-1:0]   count
);

    localparam int CW = $clog2(N + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/strip_transition_counter.sv
// Counts vertical and horizontal pixel transitions over a frame of strips.
// Two-stage datapath: per-strip counts, then saturating frame totals.
module strip_transition_counter
    import strip_feature_pkg::*;
#(
    parameter int HEIGHT = HEIGHT_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [HEIGHT-1:0] in_strip,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_vcount,
    output logic [CNT_W-1:0]  out_hcount,
    output logic [CNT_W-1:0]  out_strips,
    output logic              out_truncated
);

    localparam int VW = $clog2(HEIGHT);
    localparam int HW = $clog2(HEIGHT + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = CNT_W + HW + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t            state;
    logic              started;
    logic [HEIGHT-1:0] prev;
    logic [IW-1:0]     idx;
    mode_t             mode_q;
    mode_t             mode_eff;

    logic              s1_valid;
    logic              s1_first;
    logic              s1_end;
    logic              s1_trunc;
    logic [VW-1:0]     s1_v;
    logic [HW-1:0]     s1_h;

    logic [VW-1:0]     vc;
    logic [HW-1:0]     hc;
    logic              first;
    logic              accept;
    logic              at_max;
    logic              frame_end;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [HW-1:0]    b
    );
        logic [SW-1:0] s;
        s = SW'(a) + SW'(b);
        if (s > SW'({CNT_W{1'b1}})) begin
            return '1;
        end
        return s[CNT_W-1:0];
    endfunction

    // Stall while a frame-end strip sits in stage 1 so frames never abut.
    assign in_ready  = started && (state != HOLD) && !(s1_valid && s1_end);
    assign accept    = in_valid && in_ready && !clear;
    assign first     = (state == IDLE);
    assign mode_eff  = first ? mode : mode_q;
    assign at_max    = (idx == IW'(WIDTH - 1));
    assign frame_end = in_last || at_max;

    strip_popcount #(.N(HEIGHT - 1)) u_vpop (
        .bits  (in_strip[HEIGHT-2:0] ^ in_strip[HEIGHT-1:1]),
        .count (vc)
    );

    strip_popcount #(.N(HEIGHT)) u_hpop (
        .bits  (in_strip ^ prev),
        .count (hc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_end   <= 1'b0;
            s1_trunc <= 1'b0;
            s1_v     <= '0;
            s1_h     <= '0;
            prev     <= '0;
            idx      <= '0;
            mode_q   <= '0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_end   <= 1'b0;
            s1_trunc <= 1'b0;
            s1_v     <= '0;
            s1_h     <= '0;
            prev     <= '0;
            idx      <= '0;
            mode_q   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_first <= first;
                s1_end   <= frame_end;
                s1_trunc <= at_max && !in_last;
                s1_v     <= mode_eff[MODE_V] ? vc : '0;
                s1_h     <= (mode_eff[MODE_H] && !first) ? hc : '0;
                prev     <= in_strip;
                idx      <= frame_end ? '0 : idx + 1'b1;
                if (first) begin
                    mode_q <= mode;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            started       <= 1'b0;
            out_valid     <= 1'b0;
            out_vcount    <= '0;
            out_hcount    <= '0;
            out_strips    <= '0;
            out_truncated <= 1'b0;
        end else begin
            started <= 1'b1;
            if (clear) begin
                state         <= IDLE;
                out_valid     <= 1'b0;
                out_vcount    <= '0;
                out_hcount    <= '0;
                out_strips    <= '0;
                out_truncated <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) state <= ACCUM;
                    end
                    ACCUM: begin
                        if (s1_valid && s1_end) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
                // First strip of a frame reloads the totals instead of adding.
                if (s1_valid) begin
                    out_vcount    <= sat_add(s1_first ? '0 : out_vcount, HW'(s1_v));
                    out_hcount    <= sat_add(s1_first ? '0 : out_hcount, s1_h);
                    out_strips    <= sat_add(s1_first ? '0 : out_strips, HW'(1));
                    out_truncated <= s1_trunc;
                end
            end
        end
    end

endmodule

// File: tb/tb_strip_transition_counter.sv
// Scoreboard bench for strip_transition_counter (HEIGHT=8, WIDTH=4).
// Two instances (CNT_W=16 and CNT_W=3) share stimulus and results.
module tb_strip_transition_counter;

    localparam int H = 8;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] in_strip = 8'h00;

    logic        rdy_a, rdy_b, ov_a, ov_b, tr_a, tr_b;
    logic [15:0] v_a, h_a, s_a;
    logic [2:0]  v_b, h_b, s_b;

    typedef struct {
        int v;
        int h;
        int n;
        int tr;
        int acc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int hold_req = 0;
    int hold_done = 0;

    int         fr_n, fr_v, fr_h;
    logic [7:0] fr_prev;
    logic [1:0] fr_mode;
    bit         frame_open = 0;

    strip_transition_counter #(.HEIGHT(H), .WIDTH(W), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy_a), .in_strip(in_strip),
        .in_last(in_last), .out_valid(ov_a), .out_ready(out_ready),
        .out_vcount(v_a), .out_hcount(h_a), .out_strips(s_a),
        .out_truncated(tr_a)
    );

    strip_transition_counter #(.HEIGHT(H), .WIDTH(W), .CNT_W(3)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy_b), .in_strip(in_strip),
        .in_last(in_last), .out_valid(ov_b), .out_ready(out_ready),
        .out_vcount(v_b), .out_hcount(h_b), .out_strips(s_b),
        .out_truncated(tr_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic int sat(input int x, input int w);
        int m;
        m = (1 << w) - 1;
        return (x > m) ? m : x;
    endfunction

    function automatic int vtrans(input logic [7:0] s);
        int c;
        c = 0;
        for (int i = 0; i < H - 1; i++) begin
            if (s[i] != s[i+1]) c++;
        end
        return c;
    endfunction

    task automatic model_accept(input logic [7:0] s, input bit last, input logic [1:0] md);
        exp_t e;
        if (!frame_open) begin
            frame_open = 1;
            fr_mode = md;
            fr_n = 0;
            fr_v = 0;
            fr_h = 0;
        end
        if (fr_mode[0]) fr_v += vtrans(s);
        if (fr_mode[1] && fr_n > 0) fr_h += $countones(s ^ fr_prev);
        fr_prev = s;
        fr_n++;
        if (last || fr_n == W) begin
            e.v = fr_v;
            e.h = fr_h;
            e.n = fr_n;
            e.tr = (fr_n == W && !last) ? 1 : 0;
            e.acc = cyc;
            q.push_back(e);
            frame_open = 0;
        end
    endtask

    task automatic send_strip(input logic [7:0] s, input bit last, input logic [1:0] md);
        int waited;
        bit done;
        waited = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_strip = s;
            in_last = last;
            mode = md;
            #1;
            if (rdy_a) begin
                model_accept(s, last, md);
                done = 1;
            end else begin
                waited++;
                if (waited > 200) begin
                    chk("accept_timeout", 0, 1);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((q.size() != 0 || ov_a) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("drain_timeout", 0, 1);
        idle(2);
    endtask

    // Monitor: pops an expectation each time a new result is presented.
    bit          shown = 0;
    bit          hs_pend = 0;
    int          wait_cnt = 0;
    logic [15:0] hv, hh, hs;
    logic        ht;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            shown = 0;
            hs_pend = 0;
            out_ready = 1'b0;
        end else begin
            if (hs_pend) begin
                chk("hs_out_valid_drop", int'(ov_a), 0);
                chk("hs_in_ready_back", int'(rdy_a), 1);
                hs_pend = 0;
            end
            if (ov_a) begin
                if (!shown) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("vcount", int'(v_a), sat(e.v, 16));
                        chk("hcount", int'(h_a), sat(e.h, 16));
                        chk("strips", int'(s_a), sat(e.n, 16));
                        chk("truncated", int'(tr_a), e.tr);
                        chk("vcount_w3", int'(v_b), sat(e.v, 3));
                        chk("hcount_w3", int'(h_b), sat(e.h, 3));
                        chk("strips_w3", int'(s_b), sat(e.n, 3));
                        chk("truncated_w3", int'(tr_b), e.tr);
                        chk("out_valid_w3", int'(ov_b), 1);
                        chk("latency", cyc - e.acc, 2);
                    end
                    hv = v_a;
                    hh = h_a;
                    hs = s_a;
                    ht = tr_a;
                    shown = 1;
                    if (hold_req != hold_done) begin
                        wait_cnt = 5;
                        hold_done = hold_req;
                    end else begin
                        wait_cnt = $urandom_range(0, 3);
                    end
                end else begin
                    chk("hold_vcount", int'(v_a), int'(hv));
                    chk("hold_hcount", int'(h_a), int'(hh));
                    chk("hold_strips", int'(s_a), int'(hs));
                    chk("hold_truncated", int'(tr_a), int'(ht));
                end
                chk("hold_in_ready", int'(rdy_a), 0);
                out_ready = (wait_cnt == 0);
                if (wait_cnt > 0) wait_cnt--;
                if (out_ready) begin
                    hs_pend = 1;
                    shown = 0;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat [4];
        logic [7:0] s;
        int         nlen;
        logic [1:0] md;
        bit         last;

        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        pat[2] = 8'h55;
        pat[3] = 8'hAA;

        #1 rst_n = 1'b0;
        #3;
        chk("rst_out_valid", int'(ov_a), 0);
        chk("rst_in_ready", int'(rdy_a), 0);
        chk("rst_vcount", int'(v_a), 0);
        chk("rst_strips", int'(s_a), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", int'(rdy_a), 1);

        send_strip(8'h55, 1, 2'b01);
        wait_drain();

        send_strip(8'h00, 0, 2'b11);
        send_strip(8'hFF, 0, 2'b11);
        send_strip(8'h00, 0, 2'b11);
        send_strip(8'hFF, 0, 2'b11);
        wait_drain();

        repeat (4) send_strip(8'h55, 0, 2'b01);
        wait_drain();

        hold_req++;
        send_strip(8'hA5, 1, 2'b11);
        wait_drain();

        send_strip(8'h3C, 0, 2'b11);
        send_strip(8'hC3, 0, 2'b11);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", int'(ov_a), 0);
        chk("midreset_in_ready", int'(rdy_a), 0);
        chk("midreset_vcount", int'(v_a), 0);
        chk("midreset_hcount", int'(h_a), 0);
        chk("midreset_strips", int'(s_a), 0);
        chk("midreset_truncated", int'(tr_a), 0);
        chk("midreset_vcount_w3", int'(v_b), 0);
        frame_open = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_midreset", int'(rdy_a), 1);
        send_strip(8'h0F, 1, 2'b11);
        wait_drain();

        send_strip(8'hF0, 0, 2'b01);
        @(negedge clk);
        in_valid = 1'b1;
        in_strip = 8'hAA;
        in_last = 1'b1;
        mode = 2'b11;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        frame_open = 0;
        idle(4);
        chk("clear_out_valid", int'(ov_a), 0);
        chk("clear_strips", int'(s_a), 0);
        send_strip(8'h81, 1, 2'b01);
        wait_drain();

        for (int f = 0; f < 40; f++) begin
            nlen = $urandom_range(1, W);
            md = 2'($urandom_range(0, 3));
            for (int k = 0; k < nlen; k++) begin
                if ($urandom_range(0, 3) == 0) s = 8'($urandom);
                else s = pat[$urandom_range(0, 3)];
                last = (k == nlen - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                send_strip(s, last, md);
                idle($urandom_range(0, 2));
            end
        end
        if (frame_open) send_strip(8'h18, 1, 2'b11);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/strip_transition_counter.md
STRIP_TRANSITION_COUNTER -- requirements
Module: strip_transition_counter

Interface
REQ-001 The block SHALL have parameter HEIGHT, default 28: bits per strip (pixels per image column).
REQ-002 The block SHALL have parameter WIDTH, default 28: maximum strips per frame.
REQ-003 The block SHALL have parameter CNT_W, default 16: width of each count output.
REQ-004 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port clear  input  1  synchronous abort of the current frame.
REQ-007 The block SHALL have port mode  input  2  bit0 enables the vertical count, bit1 enables the horizontal count.
REQ-008 The block SHALL have port in_valid  input  1  strip offered.
REQ-009 The block SHALL have port in_ready  output  1  strip accepted when in_valid and in_ready are both high.
REQ-010 The block SHALL have port in_strip  input  HEIGHT  binary pixel column, bit 0 at the top.
REQ-011 The block SHALL have port in_last  input  1  final strip of the frame.
REQ-012 The block SHALL have port out_valid  output  1  frame result available.
REQ-013 The block SHALL have port out_ready  input  1  consumer takes the result.
REQ-014 The block SHALL have ports out_vcount and out_hcount  output  CNT_W  each  vertical and horizontal transition totals.
REQ-015 The block SHALL have ports out_strips  output  CNT_W  strips in frame; out_truncated  output  1  WIDTH reached without in_last.

Function
REQ-016 Vertical count per strip SHALL be the number of i in 0..HEIGHT-2 with strip[i] != strip[i+1]; all HEIGHT-1 adjacent pairs count.
REQ-017 Horizontal count per strip SHALL be popcount(strip XOR previous accepted strip); it SHALL be 0 for the first strip of a frame.
REQ-018 FSM states SHALL be IDLE, ACCUM and HOLD: IDLE->ACCUM on the first accept; ACCUM->HOLD when the frame-end strip leaves stage 1; HOLD->IDLE on out_valid and out_ready.
REQ-019 Frame end SHALL be declared on accept with in_last=1, or on accept of strip index WIDTH-1, whichever comes first.
REQ-020 out_truncated SHALL be 1 when frame end came from index WIDTH-1 with in_last=0.
REQ-021 The datapath SHALL be two stages: stage 1 registers the per-strip counts, last flag and previous strip; stage 2 accumulates into the frame totals.
REQ-022 out_valid SHALL rise exactly 2 cycles after the frame-end strip is accepted.
REQ-023 in_ready SHALL be 0 in HOLD, and 0 while stage 1 holds a frame-end strip; otherwise it SHALL be 1.
REQ-024 A frame-end strip and a new-frame strip SHALL never be accepted in consecutive cycles.
REQ-025 mode SHALL be sampled on the first accept of a frame and held for that frame; a disabled count SHALL report 0.
REQ-026 Accumulators SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 Outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 out_valid SHALL fall in the cycle after the output handshake, and in_ready SHALL return to 1 in that same cycle.
REQ-029 clear=1 SHALL, at the next edge, empty the pipeline, zero the accumulators, deassert out_valid and enter IDLE; clear takes priority over a simultaneous accept or handshake.
REQ-030 in_valid with in_ready=0 SHALL have no effect; the source holds its data.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, in_ready=0 and out_valid=0.
REQ-032 rst_n low SHALL immediately zero out_vcount, out_hcount, out_strips, out_truncated, all stage registers and the previous-strip register.
REQ-033 in_ready SHALL go to 1 on the first clk edge after rst_n deasserts.
REQ-034 Reset mid-frame SHALL discard the partial frame; no result for it SHALL ever be emitted.

Structure
REQ-035 HEIGHT and WIDTH defaults and the mode bit encoding (MODE_V=bit0, MODE_H=bit1) SHALL live in shared package strip_feature_pkg, alongside the global parameters.
REQ-036 The FSM state enum SHALL be local to the module.
REQ-037 The vertical and horizontal per-strip counts SHALL each use one instance of the combinational sub-module strip_popcount (N-bit input, clog2(N+1)-bit count).

Verification (HEIGHT=8, WIDTH=4, CNT_W=16 unless noted)
REQ-038 Single strip 8'h55, in_last=1, mode=01 accepted at cycle T -> out_valid at T+2; vcount=7, hcount=0, strips=1, truncated=0.
REQ-039 Strips 00,FF,00,FF, in_last=0, mode=11 -> vcount=0, hcount=24, strips=4, truncated=1.
REQ-040 CNT_W=3, four strips 8'h55, mode=01 -> vcount saturates at 7, not 28 mod 8.
REQ-041 out_ready held low 5 cycles -> outputs constant and in_ready=0 throughout; handshake -> out_valid low and in_ready high the next cycle.
REQ-042 rst_n pulsed low after 2 strips -> all outputs 0 asynchronously; the next frame (single strip 8'h0F, in_last=1, mode=11) -> vcount=1, hcount=0.
REQ-043 clear asserted together with a valid strip -> strip dropped, no out_valid; the following frame counts from zero.
